// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit LFSR pattern path (generator and checker).
package lfsr_pkg;

    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lfsr_state_t;

    function automatic logic [7:0] lfsr_next(input logic [7:0] state, input logic [7:0] taps);
        return {state[6:0], ^(state & taps)};
    endfunction

endpackage

// File: rtl/lfsr_checker.sv
// LFSR stream checker: self-seeds from received words, locks after a run of
// correct predictions, then counts deviations and tracks full periods.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter logic [7:0] TAPS     = LFSR_TAPS,
    parameter int         LOCK_CNT = 4,
    parameter int         LOSS_CNT = 3,
    parameter int         ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    input  logic [7:0]       data,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic             wrap_pulse
);

    localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_C = 4'(LOSS_CNT);

    lfsr_state_t      state, state_d;
    logic [7:0]       pred, pred_d;
    logic [7:0]       anchor, anchor_d;
    logic [7:0]       per_cnt, per_d;
    logic [3:0]       good_cnt, good_d;
    logic [3:0]       bad_cnt, bad_d;
    logic             locked_d, err_pulse_d, wrap_d;
    logic [ERR_W-1:0] err_cnt_d;
    logic [7:0]       seed_nxt, fly_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HUNT;
            pred       <= 8'h00;
            anchor     <= 8'h00;
            per_cnt    <= 8'h00;
            good_cnt   <= 4'd0;
            bad_cnt    <= 4'd0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
            err_count  <= '0;
        end else begin
            state      <= state_d;
            pred       <= pred_d;
            anchor     <= anchor_d;
            per_cnt    <= per_d;
            good_cnt   <= good_d;
            bad_cnt    <= bad_d;
            locked     <= locked_d;
            err_pulse  <= err_pulse_d;
            wrap_pulse <= wrap_d;
            err_count  <= err_cnt_d;
        end
    end

    always_comb begin
        state_d     = state;
        pred_d      = pred;
        anchor_d    = anchor;
        per_d       = per_cnt;
        good_d      = good_cnt;
        bad_d       = bad_cnt;
        locked_d    = locked;
        err_pulse_d = 1'b0;
        wrap_d      = 1'b0;
        err_cnt_d   = err_count;
        seed_nxt    = lfsr_next(data, TAPS);
        fly_nxt     = lfsr_next(pred, TAPS);

        if (shift) begin
            unique case (state)
                HUNT: begin
                    // All-zero is the LFSR lockup word; seeding from it would predict zeros forever.
                    if (data != 8'h00) begin
                        pred_d  = seed_nxt;
                        good_d  = 4'd0;
                        state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    if (data == pred) begin
                        pred_d = seed_nxt;
                        good_d = good_cnt + 4'd1;
                        if (good_cnt + 4'd1 == LOCK_C) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                            anchor_d = data;
                            bad_d    = 4'd0;
                            per_d    = 8'h00;
                        end
                    end else if (data != 8'h00) begin
                        pred_d = seed_nxt;
                        good_d = 4'd0;
                    end else begin
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    per_d = (per_cnt == 8'd254) ? 8'h00 : per_cnt + 8'd1;
                    if (per_cnt == 8'd254 && data == anchor)
                        wrap_d = 1'b1;
                    if (data == pred) begin
                        pred_d = seed_nxt;
                        bad_d  = 4'd0;
                    end else begin
                        // Flywheel on our own prediction so corrupt words never reseed us.
                        pred_d      = fly_nxt;
                        err_pulse_d = 1'b1;
                        bad_d       = bad_cnt + 4'd1;
                        if (err_count != '1)
                            err_cnt_d = err_count + ERR_W'(1);
                        if (bad_cnt + 4'd1 == LOSS_C) begin
                            state_d  = HUNT;
                            locked_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d  = HUNT;
                    locked_d = 1'b0;
                end
            endcase
        end

        if (clr_err)
            err_cnt_d = '0;
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: lock, errors, loss/relock, gaps, clear, saturation, reset.
module tb_lfsr_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       shift;
    logic [7:0] data;
    logic       clr_err;
    logic       locked, err_pulse, wrap_pulse;
    logic [15:0] err_count;
    logic       locked4, err_pulse4, wrap_pulse4;
    logic [3:0] err_count4;

    int checks = 0;
    int errors = 0;
    logic [7:0] nxt;

    always #5 clk = ~clk;

    lfsr_checker dut (
        .clk(clk), .rst(rst), .shift(shift), .data(data), .clr_err(clr_err),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .wrap_pulse(wrap_pulse)
    );

    lfsr_checker #(.ERR_W(4)) dut4 (
        .clk(clk), .rst(rst), .shift(shift), .data(data), .clr_err(clr_err),
        .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4), .wrap_pulse(wrap_pulse4)
    );

    // Taps at bits 7,5,4,3 written out bit by bit.
    function automatic logic [7:0] mnext(input logic [7:0] d);
        return {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
    endfunction

    // Called at a negedge; returns at the next negedge, after the sampling edge.
    task automatic drive(input logic s, input logic [7:0] d);
        shift = s;
        data  = d;
        @(negedge clk);
    endtask

    task automatic send_good();
        drive(1'b1, nxt);
        nxt = mnext(nxt);
    endtask

    task automatic send_bad(input logic [7:0] flip);
        drive(1'b1, nxt ^ flip);
        nxt = mnext(nxt);
    endtask

    task automatic test_reset();
        rst = 1'b1; clr_err = 1'b0;
        drive(1'b1, 8'h05);
        drive(1'b1, 8'h05);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", locked); end
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_err_pulse got %b want 0", err_pulse); end
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL reset_err_count got %0d want 0", err_count); end
        checks++; if (wrap_pulse !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", wrap_pulse); end
        rst = 1'b0;
        drive(1'b0, 8'h00);
    endtask

    task automatic test_clean_lock();
        nxt = 8'h05;
        for (int i = 0; i < 600; i++) begin
            send_good();
            checks++;
            if (locked !== (i >= 4)) begin errors++; $display("FAIL clean_locked word %0d got %b want %b", i, locked, (i >= 4)); end
            checks++;
            if (wrap_pulse !== (i == 259 || i == 514)) begin
                errors++; $display("FAIL clean_wrap word %0d got %b want %b", i, wrap_pulse, (i == 259 || i == 514));
            end
            checks++;
            if (err_pulse !== 1'b0) begin errors++; $display("FAIL clean_err_pulse word %0d got %b want 0", i, err_pulse); end
        end
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL clean_err_count got %0d want 0", err_count); end
    endtask

    task automatic test_single_error();
        send_bad(8'h01);
        checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL single_pulse got %b want 1", err_pulse); end
        checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL single_count got %0d want 1", err_count); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL single_locked got %b want 1", locked); end
        send_good();
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL single_next_pulse got %b want 0", err_pulse); end
        checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL single_next_count got %0d want 1", err_count); end
    endtask

    task automatic test_loss_of_lock();
        logic [7:0] p;
        clr_err = 1'b1;
        drive(1'b0, 8'h00);
        clr_err = 1'b0;
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL clr_count got %0d want 0", err_count); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL clr_locked got %b want 1", locked); end
        // Avoid positions where a predicted word is itself FF.
        while (nxt == 8'hFF || mnext(nxt) == 8'hFF || mnext(mnext(nxt)) == 8'hFF) send_good();
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, 8'hFF);
            nxt = mnext(nxt);
            checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL loss_pulse %0d got %b want 1", k, err_pulse); end
            checks++; if (err_count !== 16'(k)) begin errors++; $display("FAIL loss_count %0d got %0d want %0d", k, err_count, k); end
            checks++; if (locked !== (k < 3)) begin errors++; $display("FAIL loss_locked %0d got %b want %b", k, locked, (k < 3)); end
        end
        p = nxt;
        for (int k = 1; k <= 5; k++) begin
            send_good();
            checks++; if (locked !== (k == 5)) begin errors++; $display("FAIL relock word %0d from %h got %b want %b", k, p, locked, (k == 5)); end
        end
        checks++; if (err_count !== 16'd3) begin errors++; $display("FAIL relock_count got %0d want 3", err_count); end
    endtask

    task automatic test_zero_and_gaps();
        rst = 1'b1;
        drive(1'b0, 8'h00);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 8'h00);
            checks++; if (locked !== 1'b0) begin errors++; $display("FAIL zero_locked %0d got %b want 0", k, locked); end
        end
        nxt = 8'h05;
        for (int k = 1; k <= 8; k++) begin
            send_good();
            checks++; if (locked !== (k >= 5)) begin errors++; $display("FAIL gap_locked word %0d got %b want %b", k, locked, (k >= 5)); end
            drive(1'b0, 8'h3C);
            checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL gap_idle_pulse %0d got %b want 0", k, err_pulse); end
        end
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL gap_count got %0d want 0", err_count); end
    endtask

    task automatic test_clr_collision();
        send_bad(8'h80);
        send_good();
        checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL pre_clr_count got %0d want 1", err_count); end
        clr_err = 1'b1;
        send_bad(8'h80);
        clr_err = 1'b0;
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL clr_collide_count got %0d want 0", err_count); end
        checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL clr_collide_pulse got %b want 1", err_pulse); end
        send_good();
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 20; k++) begin
            send_bad(8'h10);
            send_good();
        end
        checks++; if (err_count4 !== 4'hF) begin errors++; $display("FAIL sat4_count got %h want f", err_count4); end
        checks++; if (err_count !== 16'd20) begin errors++; $display("FAIL sat16_count got %0d want 20", err_count); end
        checks++; if (locked4 !== 1'b1) begin errors++; $display("FAIL sat4_locked got %b want 1", locked4); end
    endtask

    task automatic test_reset_locked();
        rst = 1'b1;
        send_bad(8'h01);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rstlk_locked got %b want 0", locked); end
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL rstlk_pulse got %b want 0", err_pulse); end
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL rstlk_count got %0d want 0", err_count); end
        checks++; if (wrap_pulse !== 1'b0) begin errors++; $display("FAIL rstlk_wrap got %b want 0", wrap_pulse); end
        checks++; if (err_count4 !== 4'h0) begin errors++; $display("FAIL rstlk_count4 got %h want 0", err_count4); end
        rst = 1'b0;
        drive(1'b0, 8'h00);
    endtask

    initial begin
        rst = 1'b1; shift = 1'b0; data = 8'h00; clr_err = 1'b0; nxt = 8'h05;
        @(negedge clk);
        test_reset();
        test_clean_lock();
        test_single_error();
        test_loss_of_lock();
        test_zero_and_gaps();
        test_clr_collision();
        test_saturation();
        test_reset_locked();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
